// File: rtl/ins_cache_pkg.sv
// Shared definitions for the instruction cache:
// FSM encoding, geometry defaults and fill width.
package ins_cache_pkg;

  localparam int INDEX_BITS_DEF = 5;
  localparam int FILL_WORDS_DEF = 3;
  localparam int FILL_BITS      = 96;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ins_cache_array.sv
// Direct-mapped valid/tag/data store: one comb read port,
// FILL_WORDS synchronous write ports, async valid clear.
module ins_cache_array
  import ins_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int FILL_WORDS = FILL_WORDS_DEF,
  localparam int TAG_BITS  = 30 - INDEX_BITS,
  localparam int ENTRIES   = 1 << INDEX_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [31:0]           o_rd_data,
  input  logic                  i_wr_en,
  input  logic [FILL_WORDS-1:0][INDEX_BITS-1:0] i_wr_idx,
  input  logic [FILL_WORDS-1:0][TAG_BITS-1:0]   i_wr_tag,
  input  logic [FILL_WORDS-1:0][31:0]           i_wr_data
);

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag  [ENTRIES];
  logic [31:0]         r_data [ENTRIES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      for (int k = 0; k < FILL_WORDS; k++)
        r_valid[i_wr_idx[k]] <= 1'b1;
    end
  end

  // Tag and data payload carry no reset; valid gates them.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < FILL_WORDS; k++) begin
        r_tag[i_wr_idx[k]]  <= i_wr_tag[k];
        r_data[i_wr_idx[k]] <= i_wr_data[k];
      end
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/ins_cache.sv
// Read-only direct-mapped instruction cache with a
// three-word refill from the memory controller.
module ins_cache
  import ins_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int FILL_WORDS = FILL_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 if_req,
  input  logic [31:0]          if_pc,
  input  logic                 flush,
  output logic                 ins_valid,
  output logic [31:0]          ins_out,
  output logic                 ins_fetch_sig,
  output logic [31:0]          ins_addr,
  input  logic                 ins_fetch_done,
  input  logic [FILL_BITS-1:0] ins_data
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  state_t      r_state, w_state_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_fetch, w_fetch_nxt;
  logic        r_flushed, w_flushed_nxt;
  logic [31:0] r_out, w_out_nxt;
  logic [31:0] r_addr, w_addr_nxt;

  logic                w_rd_valid;
  logic [TAG_BITS-1:0] w_rd_tag;
  logic [31:0]         w_rd_data;
  logic                w_hit;
  logic                w_fill;

  logic [FILL_WORDS-1:0][29:0]           w_fill_word;
  logic [FILL_WORDS-1:0][INDEX_BITS-1:0] w_wr_idx;
  logic [FILL_WORDS-1:0][TAG_BITS-1:0]   w_wr_tag;
  logic [FILL_WORDS-1:0][31:0]           w_wr_data;

  // Word-address arithmetic wraps mod 2^32 and across the index.
  for (genvar k = 0; k < FILL_WORDS; k++) begin : g_fill
    assign w_fill_word[k] = r_addr[31:2] + 30'(k);
    assign w_wr_idx[k]    = w_fill_word[k][INDEX_BITS-1:0];
    assign w_wr_tag[k]    = w_fill_word[k][29:INDEX_BITS];
    assign w_wr_data[k]   = ins_data[32*k +: 32];
  end

  assign w_fill = rdy && (r_state == MISS) && ins_fetch_done;

  ins_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .FILL_WORDS (FILL_WORDS)
  ) u_array (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rd_idx   (if_pc[INDEX_BITS+1:2]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill),
    .i_wr_idx   (w_wr_idx),
    .i_wr_tag   (w_wr_tag),
    .i_wr_data  (w_wr_data)
  );

  assign w_hit = w_rd_valid &&
                 (w_rd_tag == if_pc[31:INDEX_BITS+2]);

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_fetch_nxt   = r_fetch;
    w_flushed_nxt = r_flushed;
    w_out_nxt     = r_out;
    w_addr_nxt    = r_addr;
    if (rdy) begin
      w_valid_nxt = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (if_req && !flush) begin
            if (w_hit) begin
              w_valid_nxt = 1'b1;
              w_out_nxt   = w_rd_data;
            end else begin
              w_state_nxt   = MISS;
              w_fetch_nxt   = 1'b1;
              w_addr_nxt    = if_pc;
              w_flushed_nxt = 1'b0;
            end
          end
        end
        MISS: begin
          if (flush) w_flushed_nxt = 1'b1;
          // The fetch cannot abort; a flush only drops the reply.
          if (ins_fetch_done) begin
            w_fetch_nxt = 1'b0;
            if (r_flushed || flush) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = RESP;
              w_valid_nxt = 1'b1;
              w_out_nxt   = ins_data[31:0];
            end
          end
        end
        RESP: w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_fetch   <= 1'b0;
      r_flushed <= 1'b0;
      r_out     <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_fetch   <= w_fetch_nxt;
      r_flushed <= w_flushed_nxt;
      r_out     <= w_out_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  assign ins_valid     = r_valid && !((r_state == RESP) && flush);
  assign ins_out       = r_out;
  assign ins_fetch_sig = r_fetch;
  assign ins_addr      = r_addr;

endmodule

// File: tb/tb_ins_cache.sv
// Randomized bench for ins_cache against a transaction-level
// model of a 32-entry direct-mapped word cache.
module tb_ins_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_pc;
  logic        flush;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic        ins_fetch_sig;
  logic [31:0] ins_addr;
  logic        ins_fetch_done;
  logic [95:0] ins_data;

  int n_vec = 0;
  int n_err = 0;

  bit          cm_v [32];
  logic [31:0] cm_a [32];

  ins_cache dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .if_req         (if_req),
    .if_pc          (if_pc),
    .flush          (flush),
    .ins_valid      (ins_valid),
    .ins_out        (ins_out),
    .ins_fetch_sig  (ins_fetch_sig),
    .ins_addr       (ins_addr),
    .ins_fetch_done (ins_fetch_done),
    .ins_data       (ins_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h0:   memw = 32'h00000297;
      32'h4:   memw = 32'h00100093;
      32'h8:   memw = 32'h00000013;
      default: memw = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int e;
    e = int'(a[6:2]);
    m_hit = cm_v[e] && (cm_a[e] == a);
  endfunction

  task automatic m_fill(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      w = a + 32'(4 * k);
      cm_v[int'(w[6:2])] = 1'b1;
      cm_a[int'(w[6:2])] = w;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 32; i++) cm_v[i] = 1'b0;
  endtask

  // fl: 0 none, 1 flush with request, 2 flush mid-miss,
  // 3 flush in the response cycle.
  task automatic fetch(input logic [31:0] pc, input int fl,
                       input bit stall);
    bit h;
    int d;
    h = m_hit(pc);
    if_req = 1'b1;
    if_pc  = pc;
    flush  = (fl == 1);
    @(negedge clk);
    if_req = 1'b0;
    flush  = 1'b0;
    if_pc  = $urandom;
    if (fl == 1) begin
      check("flreq_v", 32'(ins_valid), 32'd0);
      check("flreq_f", 32'(ins_fetch_sig), 32'd0);
      return;
    end
    if (h) begin
      check("hit_v", 32'(ins_valid), 32'd1);
      check("hit_d", ins_out, memw(pc));
      check("hit_f", 32'(ins_fetch_sig), 32'd0);
      @(negedge clk);
      check("hit_end", 32'(ins_valid), 32'd0);
      return;
    end
    check("miss_f", 32'(ins_fetch_sig), 32'd1);
    check("miss_a", ins_addr, pc);
    check("miss_v", 32'(ins_valid), 32'd0);
    d = $urandom_range(2, 4);
    for (int i = 0; i < d; i++) begin
      if_req = 1'($urandom);
      if_pc  = $urandom;
      flush  = (fl == 2 && i == 1);
      @(negedge clk);
      check("wait_f", 32'(ins_fetch_sig), 32'd1);
      check("wait_v", 32'(ins_valid), 32'd0);
    end
    if_req = 1'b0;
    flush  = 1'b0;
    if (stall) begin
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
        ins_fetch_done = (i == 2);
        ins_data = {$urandom, $urandom, $urandom};
        @(negedge clk);
        check("stall_f", 32'(ins_fetch_sig), 32'd1);
        check("stall_v", 32'(ins_valid), 32'd0);
        check("stall_a", ins_addr, pc);
      end
      ins_fetch_done = 1'b0;
      rdy = 1'b1;
    end
    ins_fetch_done = 1'b1;
    ins_data = {memw(pc + 32'd8), memw(pc + 32'd4), memw(pc)};
    @(negedge clk);
    ins_fetch_done = 1'b0;
    ins_data = {3{$urandom}};
    m_fill(pc);
    check("done_f", 32'(ins_fetch_sig), 32'd0);
    if (fl == 2) begin
      check("flmiss_v", 32'(ins_valid), 32'd0);
      @(negedge clk);
      check("flmiss_v2", 32'(ins_valid), 32'd0);
      return;
    end
    if (fl == 3) begin
      flush = 1'b1;
      #1;
      check("flresp_v", 32'(ins_valid), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      check("flresp_v2", 32'(ins_valid), 32'd0);
      return;
    end
    check("resp_v", 32'(ins_valid), 32'd1);
    check("resp_d", ins_out, memw(pc));
    @(negedge clk);
    check("resp_end", 32'(ins_valid), 32'd0);
  endtask

  task automatic reset_mid_miss(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    @(negedge clk);
    if_req = 1'b0;
    check("rm_f0", 32'(ins_fetch_sig), 32'(!m_hit(pc)));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm_f", 32'(ins_fetch_sig), 32'd0);
    check("rm_a", ins_addr, 32'd0);
    check("rm_v", 32'(ins_valid), 32'd0);
    check("rm_o", ins_out, 32'd0);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int fl;
    rst = 1'b1;
    rdy = 1'b1;
    if_req = 1'b0;
    if_pc = '0;
    flush = 1'b0;
    ins_fetch_done = 1'b0;
    ins_data = '0;
    m_clear();
    repeat (2) @(negedge clk);
    check("rst_v", 32'(ins_valid), 32'd0);
    check("rst_o", ins_out, 32'd0);
    check("rst_f", 32'(ins_fetch_sig), 32'd0);
    check("rst_a", ins_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fetch(32'h0, 0, 1'b0);
    fetch(32'h4, 0, 1'b0);
    fetch(32'h8, 0, 1'b0);
    fetch(32'h80, 0, 1'b0);
    fetch(32'h0, 0, 1'b0);
    fetch(32'h78, 0, 1'b0);
    fetch(32'h80, 0, 1'b0);
    fetch(32'h7C, 0, 1'b0);
    fetch(32'h100, 2, 1'b0);
    fetch(32'h104, 0, 1'b0);
    fetch(32'h104, 1, 1'b0);
    fetch(32'h200, 3, 1'b0);
    fetch(32'h204, 0, 1'b0);
    fetch(32'h300, 0, 1'b1);
    reset_mid_miss(32'h400);
    fetch(32'h0, 0, 1'b0);
    fetch(32'hFFFFFFFC, 0, 1'b0);
    fetch(32'h4, 0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 19) == 0)
        pc = 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4);
      else
        pc = 32'($urandom_range(0, 3) * 128 +
                 $urandom_range(0, 31) * 4);
      fl = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      fetch(pc, fl, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
